// File: rtl/memory2_pkg.sv
// memory2_pkg -- types shared by the memory2 pipeline stage and its neighbours.
//   memory1_memory2_pass_t   : instruction handed from memory1 into memory2
//   memory2_writeback_pass_t : result handed from memory2 to writeback
//   excp_pass_t              : exception record travelling with an instruction
//   forward_req_t            : register forwarding source for decode/execute
//   mem2_state_t             : memory2 load-response FSM states
//   BYTE / HALF_WORD / WORD  : load access size encodings
// Optional feature macro: MEM2_DIFFTEST_EN adds difftest fields to the
// writeback pass structure.
package memory2_pkg;

    localparam logic [1:0] BYTE      = 2'd0;
    localparam logic [1:0] HALF_WORD = 2'd1;
    localparam logic [1:0] WORD      = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } mem2_state_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  ecode;
        logic [31:0] badv;
    } excp_pass_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  idx;
        logic        data_valid;
        logic [31:0] data;
    } forward_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        is_wr_rd;
        logic        is_wr_rd_pc_plus4;
        logic [31:0] pc_plus4;
        logic [31:0] ex_out;
        logic        is_mem;
        logic        is_store;
        logic        is_signed;
        logic [1:0]  byte_type;
        logic [31:0] va;
        logic [31:0] pa;
        logic [31:0] st_data;
        logic [3:0]  byte_valid;
        logic        is_wr_csr;
        logic [13:0] csr_addr;
        logic [31:0] csr_data;
    } memory1_memory2_pass_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        is_wr_rd;
        logic [31:0] wr_data;
        logic        is_wr_csr;
        logic [13:0] csr_addr;
        logic [31:0] csr_data;
`ifdef MEM2_DIFFTEST_EN
        logic [31:0] inst;
        logic        is_ld;
        logic        is_st;
        logic [31:0] pa;
        logic [31:0] va;
        logic [31:0] st_data;
        logic [3:0]  byte_valid;
        logic [31:0] ld_data;
`endif
    } memory2_writeback_pass_t;

endpackage

// File: rtl/memory2_load_align.sv
// load_align -- selects and extends the loaded value from a 32-bit data word.
//   word      : raw dcache word
//   byte_en   : low two address bits of the access
//   byte_type : BYTE / HALF_WORD / WORD
//   is_signed : 1 = sign-extend, 0 = zero-extend
//   result    : aligned, extended load value
import memory2_pkg::*;

module load_align (
    input  logic [31:0] word,
    input  logic [1:0]  byte_en,
    input  logic [1:0]  byte_type,
    input  logic        is_signed,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte/half, then extend according to access size.
    always_comb begin
        w_byte = 8'd0;
        w_half = 16'd0;
        result = 32'd0;
        case (byte_en)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            2'd3:    w_byte = word[31:24];
            default: w_byte = 8'd0;
        endcase
        if (byte_en[1]) begin
            w_half = word[31:16];
        end else begin
            w_half = word[15:0];
        end
        case (byte_type)
            BYTE:      result = {{24{is_signed & w_byte[7]}}, w_byte};
            HALF_WORD: result = {{16{is_signed & w_half[15]}}, w_half};
            WORD:      result = word;
            default:   result = word;
        endcase
    end

endmodule

// File: rtl/memory2.sv
// memory2 -- second memory pipeline stage: waits for the dcache response of a
// load, aligns it, and hands results to writeback with forwarding info.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : kill the instruction held in this stage
//   next_rdy_in         : writeback can accept this cycle
//   rdy_in              : this stage can accept pass_in this cycle
//   pass_in/excp_pass_in: instruction and exception from memory1
//   dcache_data(_valid) : load response word, one-cycle pulse per load
//   fwd_req             : forwarding source for decode/execute
//   pass_out            : result to writeback, qualified by .valid
//   excp_pass_out       : exception to writeback
// Optional feature macro: MEM2_DIFFTEST_EN (difftest fields on pass_out).
import memory2_pkg::*;

module memory2 (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    next_rdy_in,
    output logic                    rdy_in,
    input  memory1_memory2_pass_t   pass_in,
    input  excp_pass_t              excp_pass_in,
    input  logic [31:0]             dcache_data,
    input  logic                    dcache_data_valid,
    output forward_req_t            fwd_req,
    output memory2_writeback_pass_t pass_out,
    output excp_pass_t              excp_pass_out
);

    memory1_memory2_pass_t r_pass;
    excp_pass_t            r_excp;
    mem2_state_t           r_state;
    mem2_state_t           w_state_nxt;
    logic [31:0]           r_hold_buf;

    logic        w_is_load;
    logic        w_in_drain;
    logic        w_result_avail;
    logic        w_out_valid;
    logic        w_hold_cap;
    logic [31:0] w_ld_word;
    logic [31:0] w_ld_data;
    logic [31:0] w_wr_data;

    // A load with a pending exception never issued to the dcache.
    assign w_is_load      = r_pass.valid & r_pass.is_mem & ~r_pass.is_store & ~r_excp.valid;
    assign w_in_drain     = (r_state == DRAIN);
    assign w_result_avail = ~w_is_load | (r_state == HOLD) | dcache_data_valid;
    assign w_out_valid    = r_pass.valid & ~flush & ~w_in_drain & w_result_avail & next_rdy_in;
    assign w_hold_cap     = w_is_load & ~flush & dcache_data_valid & ~next_rdy_in
                            & ((r_state == IDLE) | (r_state == WAIT));
    // Bypass the live response, otherwise use the parked word.
    assign w_ld_word      = dcache_data_valid ? dcache_data : r_hold_buf;

    load_align u_load_align (
        .word      (w_ld_word),
        .byte_en   (r_pass.va[1:0]),
        .byte_type (r_pass.byte_type),
        .is_signed (r_pass.is_signed),
        .result    (w_ld_data)
    );

    // Ready: never while draining an orphan response; a flush always frees the slot.
    always_comb begin
        rdy_in = 1'b0;
        if (w_in_drain) begin
            rdy_in = 1'b0;
        end else if (flush | ~r_pass.valid) begin
            rdy_in = 1'b1;
        end else begin
            rdy_in = next_rdy_in & w_result_avail;
        end
    end

    // Write-back data source selection.
    always_comb begin
        w_wr_data = r_pass.ex_out;
        if (w_is_load) begin
            w_wr_data = w_ld_data;
        end else if (r_pass.is_wr_rd_pc_plus4) begin
            w_wr_data = r_pass.pc_plus4;
        end else begin
            w_wr_data = r_pass.ex_out;
        end
    end

    // Load-response FSM next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_is_load & ~flush & ~dcache_data_valid) begin
                    w_state_nxt = WAIT;
                end else if (w_hold_cap) begin
                    w_state_nxt = HOLD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                // A response arriving with the flush is consumed and dropped here.
                if (flush) begin
                    w_state_nxt = dcache_data_valid ? IDLE : DRAIN;
                end else if (dcache_data_valid) begin
                    w_state_nxt = next_rdy_in ? IDLE : HOLD;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            HOLD: begin
                if (flush | next_rdy_in) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            DRAIN: begin
                if (dcache_data_valid) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state, input register and hold buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pass     <= '0;
            r_excp     <= '0;
            r_hold_buf <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (rdy_in) begin
                r_pass <= pass_in;
                r_excp <= excp_pass_in;
            end else if (flush) begin
                r_pass.valid <= 1'b0;
            end
            if (w_hold_cap) begin
                r_hold_buf <= dcache_data;
            end else if ((r_state == HOLD) & flush) begin
                r_hold_buf <= 32'd0;
            end
        end
    end

    // Output assembly toward writeback and forwarding.
    always_comb begin
        pass_out           = '0;
        pass_out.valid     = w_out_valid;
        pass_out.pc        = r_pass.pc;
        pass_out.rd        = r_pass.rd;
        pass_out.is_wr_rd  = r_pass.is_wr_rd;
        pass_out.wr_data   = w_wr_data;
        pass_out.is_wr_csr = r_pass.is_wr_csr;
        pass_out.csr_addr  = r_pass.csr_addr;
        pass_out.csr_data  = r_pass.csr_data;
`ifdef MEM2_DIFFTEST_EN
        pass_out.inst       = r_pass.inst;
        pass_out.is_ld      = r_pass.is_mem & ~r_pass.is_store;
        pass_out.is_st      = r_pass.is_mem & r_pass.is_store;
        pass_out.pa         = r_pass.pa;
        pass_out.va         = r_pass.va;
        pass_out.st_data    = r_pass.st_data;
        pass_out.byte_valid = r_pass.byte_valid;
        pass_out.ld_data    = w_ld_data;
`endif
        fwd_req            = '0;
        fwd_req.valid      = r_pass.is_wr_rd & (r_pass.rd != 5'd0) & r_pass.valid
                             & ~flush & ~w_in_drain;
        fwd_req.idx        = r_pass.rd;
        fwd_req.data_valid = w_result_avail;
        fwd_req.data       = w_wr_data;
        if (w_out_valid) begin
            excp_pass_out = r_excp;
        end else begin
            excp_pass_out = '0;
        end
    end

endmodule
